// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D cache line-port arbiter: FSM state encoding and
// requester identifiers used by the round-robin tie-break.
package arb_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/pmem_arbiter.sv
// Arbitrates the single memory line port between the I-cache (read-only) and
// the D-cache (read / write-back). One transaction at a time, round-robin on ties.
module pmem_arbiter
  import arb_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,

  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  arb_state_t            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic i_req, d_req, winner;

  // On a tie the requester that was not served last wins.
  function automatic logic pick_winner(input logic i_r, input logic d_r, input logic last);
    if (i_r && d_r) return ~last;
    return d_r ? REQ_D : REQ_I;
  endfunction

  assign i_req  = i_pmem_read;
  assign d_req  = d_pmem_read | d_pmem_write;
  assign winner = pick_winner(i_req, d_req, last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = winner;
          if (winner == REQ_D) begin
            addr_d  = d_pmem_address;
            wdata_d = d_pmem_wdata;
            // A simultaneous read+write from the D-cache is treated as a write.
            write_d = d_pmem_write;
            state_d = SERVE_D;
          end else begin
            addr_d  = i_pmem_address;
            write_d = 1'b0;
            state_d = SERVE_I;
          end
        end
      end
      SERVE_I: begin
        mem_read  = ~write_q;
        mem_write = write_q;
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      SERVE_D: begin
        mem_read  = ~write_q;
        mem_write = write_q;
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  // Read data is broadcast; only the owner's resp qualifies it.
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed and randomized bench for pmem_arbiter with a transaction-level
// reference model of the round-robin grant order.
module tb_pmem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  pmem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: outstanding request per requester (0 = I, 1 = D)
  // and who was served most recently.
  logic [AW-1:0] req_addr [2];
  logic [LW-1:0] req_wdata[2];
  logic          req_rd   [2];
  logic          req_wr   [2];
  bit            pend     [2];
  bit            last_m;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic bit model_owner();
    if (pend[0] && pend[1]) return !last_m;
    return pend[1];
  endfunction

  task automatic drive_req(input bit r);
    if (r == 1'b0) begin
      i_pmem_read    = 1'b1;
      i_pmem_address = req_addr[0];
    end else begin
      d_pmem_read    = req_rd[1];
      d_pmem_write   = req_wr[1];
      d_pmem_address = req_addr[1];
      d_pmem_wdata   = req_wdata[1];
    end
  endtask

  task automatic drop_req(input bit r);
    if (r == 1'b0) i_pmem_read = 1'b0;
    else begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  // op: 0 read, 1 write, 2 read+write (write must win)
  task automatic set_req(input bit r, input logic [AW-1:0] a, input int op);
    req_addr[r]  = a;
    req_wdata[r] = rand_line();
    req_rd[r]    = (r == 1'b0) || (op != 1);
    req_wr[r]    = (r == 1'b1) && (op != 0);
    pend[r]      = 1'b1;
    drive_req(r);
  endtask

  task automatic new_req(input bit r);
    logic [AW-1:0] a;
    a = ($urandom & 32'hFFFF_FFC0) | (r ? 32'h20 : 32'h0);
    set_req(r, a, r ? int'($urandom_range(0, 2)) : 0);
  endtask

  // Called just after a rising edge with the DUT idle or about to be.
  task automatic serve(input bit own, input int hold, input bit corrupt, input bit keep);
    int            n;
    logic [LW-1:0] rd;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_read || mem_write) break;
    end
    check("grant_latency", n, 2);
    check("mem_address", mem_address, req_addr[own]);
    check("mem_write", mem_write, req_wr[own]);
    check("mem_read", mem_read, !req_wr[own]);
    if (req_wr[own]) check("mem_wdata", mem_wdata, req_wdata[own]);
    if (corrupt) begin
      #1;
      if (own) begin
        d_pmem_address = req_addr[1] ^ 32'h300;
        d_pmem_wdata   = rand_line();
      end else i_pmem_address = req_addr[0] ^ 32'h300;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("addr_held", mem_address, req_addr[own]);
      if (req_wr[own]) check("wdata_held", mem_wdata, req_wdata[own]);
      check("early_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    end
    #1;
    rd        = rand_line();
    mem_rdata = rd;
    mem_resp  = 1'b1;
    #1;
    check("owner_resp", own ? d_pmem_resp : i_pmem_resp, 1'b1);
    check("other_resp", own ? i_pmem_resp : d_pmem_resp, 1'b0);
    check("i_rdata", i_pmem_rdata, rd);
    check("d_rdata", d_pmem_rdata, rd);
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    last_m   = own;
    if (!keep) begin
      drop_req(own);
      pend[own] = 1'b0;
    end
  endtask

  initial begin
    rst            = 1'b0;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    mem_rdata      = '0;
    mem_resp       = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last_m  = 1'b0;

    // Reset state
    #3;
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // Lone I read
    set_req(1'b0, 32'h0000_1000, 0);
    serve(model_owner(), 3, 1'b0, 1'b0);

    // Simultaneous I read and D write: D wins, I follows after a bubble
    set_req(1'b0, 32'h0000_3000, 0);
    set_req(1'b1, 32'h0000_2000, 1);
    serve(model_owner(), 1, 1'b0, 1'b0);
    serve(model_owner(), 2, 1'b0, 1'b0);

    // Both held continuously: strict alternation
    set_req(1'b0, 32'h0000_4000, 0);
    set_req(1'b1, 32'h0000_5000, 2);
    for (int t = 0; t < 6; t++) serve(model_owner(), t % 3, 1'b0, 1'b1);
    drop_req(1'b0);
    drop_req(1'b1);
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // D address changes mid-transaction (0x100 -> 0x200) must be ignored
    set_req(1'b1, 32'h0000_0100, 0);
    serve(model_owner(), 3, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an I transaction
    set_req(1'b0, 32'h0000_6000, 0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem_read", mem_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_mem_read", mem_read, 1'b0);
    check("async_mem_write", mem_write, 1'b0);
    check("async_mem_address", mem_address, '0);
    check("async_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    drop_req(1'b0);
    pend[0] = 1'b0;
    last_m  = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    set_req(1'b1, 32'h0000_7000, 0);
    serve(model_owner(), 0, 1'b0, 1'b0);

    // Stray mem_resp while idle
    mem_resp = 1'b1;
    @(negedge clk);
    check("idle_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    check("idle_strobe", {mem_read, mem_write}, 2'b00);
    @(posedge clk);
    #1 mem_resp = 1'b0;
    @(negedge clk);
    check("idle_after_resp", {mem_read, mem_write}, 2'b00);
    @(posedge clk);
    #1;
    set_req(1'b0, 32'h0000_8000, 0);
    serve(model_owner(), 1, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      bit other;
      other = !last_m;
      if (!pend[other] && $urandom_range(0, 1) == 1) new_req(other);
      if (!pend[other]) begin
        @(negedge clk);
        check("rand_idle", {mem_read, mem_write}, 2'b00);
        @(posedge clk);
        #1;
        case ($urandom_range(0, 2))
          0:       new_req(1'b0);
          1:       new_req(1'b1);
          default: begin new_req(1'b0); new_req(1'b1); end
        endcase
      end
      serve(model_owner(), int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory / cacheline port between the instruction cache (read-only) and the data cache (read and write-back).
- Accepts 256-bit line requests from both caches and grants one at a time, round-robin on ties.
- Latches the winner's address and write data, drives the downstream port, and routes the response back to the winner only.
- Sits between the two pipelined caches and the memory-side line interface.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- ADDR_WIDTH, 32, physical address width.

Ports:
- clk  in  1  clock; all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- i_pmem_read  in  1  I-cache line read request.
- i_pmem_address  in  ADDR_WIDTH  I-cache line address.
- i_pmem_rdata  out  LINE_WIDTH  line data to I-cache.
- i_pmem_resp  out  1  I-cache transaction complete.
- d_pmem_read  in  1  D-cache line read request.
- d_pmem_write  in  1  D-cache line write-back request.
- d_pmem_address  in  ADDR_WIDTH  D-cache line address.
- d_pmem_wdata  in  LINE_WIDTH  D-cache write-back data.
- d_pmem_rdata  out  LINE_WIDTH  line data to D-cache.
- d_pmem_resp  out  1  D-cache transaction complete.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  LINE_WIDTH  downstream write data.
- mem_rdata  in  LINE_WIDTH  downstream read data.
- mem_resp  in  1  downstream completion.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Registers: state, last_grant (0 = I, 1 = D), addr_q, wdata_q, write_q.
- Reset (rst low, asynchronous):
  - state=IDLE, last_grant=0, addr_q=0, wdata_q=0, write_q=0.
  - All outputs 0: mem_read, mem_write, mem_address, mem_wdata, both resp.
  - Reset mid-transaction abandons it; downstream and caches are reset in the same domain.
- IDLE:
  - Request pending means i_pmem_read for I, and d_pmem_read or d_pmem_write for D.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant. After reset, D wins the first tie.
  - On grant edge: latch address, and for D also wdata and write_q=d_pmem_write. I grants force write_q=0. Update last_grant. Go to SERVE_x.
  - D asserting read and write together is illegal; write wins.
- SERVE_x:
  - mem_read = !write_q; mem_write = write_q.
  - mem_address = addr_q; mem_wdata = wdata_q.
  - Requester input changes are ignored; no preemption.
- On mem_resp in SERVE_x:
  - x_pmem_resp = 1 in the same cycle (combinational); go to IDLE on the next edge.
  - The non-owner resp is always 0.
- Outside SERVE states, mem_read, mem_write and both resp are 0.
- mem_rdata is broadcast to both i_pmem_rdata and d_pmem_rdata unconditionally; only resp qualifies it.
- Latency:
  - Request seen in IDLE at cycle t gives downstream strobe at t+1.
  - mem_resp at cycle t+k gives requester resp at t+k and IDLE at t+k+1.
  - Earliest next downstream strobe is t+k+2, a one-cycle bubble.
- Caches deassert request the cycle after resp, so IDLE never re-grants a completed request.
- mem_resp while in IDLE is ignored.

Decomposition:
- Shared package arb_types holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - requester id constants REQ_I=1'b0, REQ_D=1'b1.
- No sub-module. Tie-break is a two-line function inside the block.

Test Plan:
- Reset then I read 0x0000_1000 alone: mem_read=1 with mem_address=0x0000_1000 one cycle later. mem_resp after 4 cycles with rdata=0xA5.. gives i_pmem_resp=1 and i_pmem_rdata=0xA5.. that cycle; d_pmem_resp stays 0.
- I read and D write 0x0000_2000 simultaneously after reset: D granted first (mem_write=1, wdata passed). After its resp, I is granted with one idle bubble.
- Both requesters held continuously for 6 transactions: grants alternate D,I,D,I,D,I with no starvation.
- D changes d_pmem_address mid-SERVE_D from 0x100 to 0x200: mem_address stays 0x100 until mem_resp.
- rst pulled low asynchronously mid SERVE_I between clock edges: mem_read and outputs drop to 0 immediately. After release, state is IDLE and a fresh D request is granted next cycle.
- mem_resp pulsed while IDLE with no requests: no resp to either cache, state remains IDLE.
